// File: rtl/mem_pkg.sv
// mem_responder shared types and constants.
// Holds the FSM state encoding and the word/wait limits.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_state_t;

  localparam int WORD_BYTES = 4;
  localparam int MAX_WAIT   = 15;

endpackage

// File: rtl/mem_responder_if.sv
// Request/ack memory bus between datapath and mem_responder.
// The be lane-enable signal exists only when MEM_BYTE_EN is defined.
interface mem_responder_if #(
  parameter int DATA_W = 32
);

  logic              req;
  logic              we;
  logic [31:0]       addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              err;
  logic              busy;
`ifdef MEM_BYTE_EN
  logic [DATA_W/8-1:0] be;

  modport master (
    output req, we, addr, wdata, be,
    input  rdata, ack, err, busy
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output rdata, ack, err, busy
  );
`else
  modport master (
    output req, we, addr, wdata,
    input  rdata, ack, err, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack, err, busy
  );
`endif

endinterface

// File: rtl/mem_array.sv
// Word-organised single-port storage with byte-lane writes.
// Read port is registered and only updates on a read or clear.
module mem_array #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_we,
  input  logic                i_re,
  input  logic                i_clr,
  input  logic [ADDR_W-1:0]   i_idx,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W/8-1:0] i_be,
  output logic [DATA_W-1:0]   o_rdata
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  // storage: lane-masked write, contents survive reset
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int i = 0; i < NB; i++) begin
        if (i_be[i]) begin
          r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end
    end
  end

  // read register: holds between accesses, cleared on rejected access
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else if (i_clr) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Memory responder: req/ack FSM with WAIT_CYC wait states.
// Optional MEM_BYTE_EN adds per-lane write enables on the bus.
import mem_pkg::*;

module mem_responder #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 8,
  parameter int WAIT_CYC = 2
) (
  input  logic           clock,
  input  logic           reset,
  mem_responder_if.slave bus
);

  localparam int NB    = DATA_W / 8;
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WC = CNT_W'(WAIT_CYC);

  mem_state_t        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic [31:0]       r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_ack;
  logic              r_err;
  logic              r_busy;
`ifdef MEM_BYTE_EN
  logic [NB-1:0]     r_be;
`endif

  logic              w_sel;
  logic              w_we;
  logic [31:0]       w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [NB-1:0]     w_be;
  logic              w_mis;
  logic [ADDR_W-1:0] w_idx;
  logic              w_idle_go;
  logic              w_wait_go;
  logic              w_go;
  logic              w_unused;

  // with zero wait states the live bus is used on the capture edge
  assign w_sel   = (r_state == IDLE);
  assign w_we    = w_sel ? bus.we    : r_we;
  assign w_addr  = w_sel ? bus.addr  : r_addr;
  assign w_wdata = w_sel ? bus.wdata : r_wdata;
`ifdef MEM_BYTE_EN
  assign w_be    = w_sel ? bus.be    : r_be;
`else
  assign w_be    = '1;
`endif
  assign w_mis   = |w_addr[1:0];
  assign w_idx   = w_addr[ADDR_W+1:2];
  assign w_unused = &{1'b0, w_addr[31:ADDR_W+2]};

  assign w_idle_go = (r_state == IDLE) && bus.req;
  assign w_wait_go = (r_state == WAIT) &&
                     (r_cnt + CNT_W'(1) == WC);
  assign w_go = reset &&
                ((WAIT_CYC == 0) ? w_idle_go : w_wait_go);

  mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .i_clk   (clock),
    .i_rst_n (reset),
    .i_we    (w_go && w_we && !w_mis),
    .i_re    (w_go && !w_we && !w_mis),
    .i_clr   (w_go && w_mis),
    .i_idx   (w_idx),
    .i_wdata (w_wdata),
    .i_be    (w_be),
    .o_rdata (bus.rdata)
  );

  // control FSM: capture, count wait states, one-cycle ack
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
`ifdef MEM_BYTE_EN
      r_be    <= '0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.req) begin
            r_we    <= bus.we;
            r_addr  <= bus.addr;
            r_wdata <= bus.wdata;
`ifdef MEM_BYTE_EN
            r_be    <= bus.be;
`endif
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            if (WAIT_CYC == 0) begin
              r_state <= RESP;
              r_ack   <= 1'b1;
              r_err   <= w_mis;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_wait_go) begin
            r_state <= RESP;
            r_ack   <= 1'b1;
            r_err   <= w_mis;
          end
        end
        RESP: begin
          r_state <= IDLE;
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack  = r_ack;
  assign bus.err  = r_err;
  assign bus.busy = r_busy;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (WAIT_CYC=2 and WAIT_CYC=0).
// Byte-lane vectors run only when MEM_BYTE_EN is defined.
module tb_mem_responder;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  mem_responder_if #(.DATA_W(32)) b0 ();
  mem_responder_if #(.DATA_W(32)) b1 ();

  mem_responder #(
    .DATA_W   (32),
    .ADDR_W   (8),
    .WAIT_CYC (2)
  ) u0 (
    .clock (clk),
    .reset (rst_n),
    .bus   (b0)
  );

  mem_responder #(
    .DATA_W   (32),
    .ADDR_W   (8),
    .WAIT_CYC (0)
  ) u1 (
    .clock (clk),
    .reset (rst_n),
    .bus   (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // one request on b0; lat = negedges after capture edge until ack
  task automatic xfer(input  logic        we,
                      input  logic [31:0] a,
                      input  logic [31:0] d,
                      input  logic [3:0]  be,
                      output logic [31:0] rd,
                      output logic        er,
                      output int          lat);
    @(negedge clk);
    b0.req   = 1'b1;
    b0.we    = we;
    b0.addr  = a;
    b0.wdata = d;
`ifdef MEM_BYTE_EN
    b0.be    = be;
`else
    if (be == 4'h0) b0.wdata = d;
`endif
    lat = 0;
    rd  = '0;
    er  = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (b0.ack) begin
        lat = k;
        rd  = b0.rdata;
        er  = b0.err;
        break;
      end
    end
    b0.req = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  logic        seen;

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    b0.req   = 1'b0;
    b0.we    = 1'b0;
    b0.addr  = '0;
    b0.wdata = '0;
    b1.req   = 1'b0;
    b1.we    = 1'b0;
    b1.addr  = '0;
    b1.wdata = '0;
`ifdef MEM_BYTE_EN
    b0.be    = 4'hF;
    b1.be    = 4'hF;
`endif
    repeat (3) @(negedge clk);
    chk("rst_ack",   32'(b0.ack),  32'd0);
    chk("rst_err",   32'(b0.err),  32'd0);
    chk("rst_busy",  32'(b0.busy), 32'd0);
    chk("rst_rdata", b0.rdata,     32'd0);
    rst_n = 1'b1;

    // write then read, 3-cycle latency
    xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    chk("wr10_lat", 32'(lat), 32'd3);
    chk("wr10_err", 32'(er),  32'd0);
    xfer(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
    chk("rd10_lat",  32'(lat), 32'd3);
    chk("rd10_data", rd,       32'hDEADBEEF);
    chk("rd10_err",  32'(er),  32'd0);
    @(negedge clk);
    chk("post_ack",  32'(b0.ack),  32'd0);
    chk("post_busy", 32'(b0.busy), 32'd0);
    chk("rd_hold",   b0.rdata,     32'hDEADBEEF);

    // misaligned accesses are rejected with no effect
    xfer(1'b0, 32'h13, 32'h0, 4'hF, rd, er, lat);
    chk("mis_lat",  32'(lat), 32'd3);
    chk("mis_err",  32'(er),  32'd1);
    chk("mis_data", rd,       32'd0);
    xfer(1'b1, 32'h11, 32'h0BADF00D, 4'hF, rd, er, lat);
    chk("miswr_err", 32'(er), 32'd1);
    xfer(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
    chk("rd10_again", rd,      32'hDEADBEEF);
    chk("rd10_aerr",  32'(er), 32'd0);

    // address wraps modulo 1 KiB
    xfer(1'b1, 32'h400, 32'h12345678, 4'hF, rd, er, lat);
    xfer(1'b0, 32'h0, 32'h0, 4'hF, rd, er, lat);
    chk("wrap_data", rd, 32'h12345678);
    xfer(1'b0, 32'h3FC, 32'h0, 4'hF, rd, er, lat);
    xfer(1'b0, 32'hFFFF_FC10, 32'h0, 4'hF, rd, er, lat);
    chk("wrap_hi", rd, 32'hDEADBEEF);

    // reset during wait state aborts the write
    xfer(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, rd, er, lat);
    @(negedge clk);
    b0.req   = 1'b1;
    b0.we    = 1'b1;
    b0.addr  = 32'h20;
    b0.wdata = 32'hAAAA5555;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy1", 32'(b0.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy0", 32'(b0.busy), 32'd0);
    chk("abort_rdata", b0.rdata,     32'd0);
    b0.req = 1'b0;
    seen = b0.ack;
    repeat (3) begin
      @(negedge clk);
      seen = seen | b0.ack;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      seen = seen | b0.ack;
    end
    chk("abort_noack", 32'(seen), 32'd0);
    xfer(1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat);
    chk("abort_keep", rd, 32'hCAFEF00D);

`ifdef MEM_BYTE_EN
    xfer(1'b1, 32'h30, 32'h11223344, 4'hF, rd, er, lat);
    xfer(1'b1, 32'h30, 32'hFFFFFFFF, 4'b0101, rd, er, lat);
    chk("be_err", 32'(er), 32'd0);
    xfer(1'b0, 32'h30, 32'h0, 4'hF, rd, er, lat);
    chk("be_data", rd, 32'h11FF33FF);
    xfer(1'b1, 32'h30, 32'h0, 4'b0000, rd, er, lat);
    chk("be0_lat", 32'(lat), 32'd3);
    chk("be0_err", 32'(er),  32'd0);
    xfer(1'b0, 32'h30, 32'h0, 4'hF, rd, er, lat);
    chk("be0_data", rd, 32'h11FF33FF);
`endif

    // zero wait states, three reads with req held high
    @(negedge clk);
    b1.req  = 1'b1;
    b1.we   = 1'b0;
    b1.addr = 32'h4;
    for (int k = 1; k <= 7; k++) begin
      logic [31:0] e;
      e = (k == 1 || k == 3 || k == 5) ? 32'd1 : 32'd0;
      @(negedge clk);
      chk($sformatf("b2b_ack%0d", k),  32'(b1.ack),  e);
      chk($sformatf("b2b_busy%0d", k), 32'(b1.busy), e);
      if (k == 5) b1.req = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
